// File: rtl/spi_2_pkg.sv
// Shared types and constants for the SPI master driver: instruction layout,
// transfer-type encoding and the driver FSM states.
package spi_2_pkg;

    localparam int DWIDTH    = 32;
    localparam int AWIDTH    = 8;
    localparam int INSTR_W   = DWIDTH + AWIDTH + 5;
    // t_type occupies the two most significant instruction bits
    localparam int TTYPE_LSB = INSTR_W - 2;

    typedef enum logic [1:0] {
        T_WRITE       = 2'b00,
        T_READ        = 2'b01,
        T_WRITE_BURST = 2'b10,
        T_READ_BURST  = 2'b11
    } t_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_BURST = 2'b10,
        ST_ABORT = 2'b11
    } drv_state_e;

    function automatic t_type_e get_t_type(input logic [INSTR_W-1:0] instr);
        return t_type_e'(instr[TTYPE_LSB +: 2]);
    endfunction

endpackage

// File: rtl/spi_2_fifo.sv
// Synchronous FIFO with flush; read data is the head word, zero when empty.
module spi_2_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == DEPTH_CNT);
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign count     = count_r;
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Head word presented combinationally, forced to zero when nothing is stored.
    always_comb begin
        rdata = {WIDTH{1'b0}};
        if (empty) begin
            rdata = {WIDTH{1'b0}};
        end else begin
            rdata = mem_r[rd_ptr_r];
        end
    end

    // Pointer and occupancy tracking; reset and flush both discard contents.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= wdata;
    end

endmodule

// File: rtl/spi_2_driver.sv
// Host-side SPI master driver: queues instructions for the master, tracks the
// outstanding read and buffers returned read data for the host.
module spi_2_driver
    import spi_2_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [INSTR_W-1:0] cmd_data,
    input  logic               cfg_wr,
    input  logic [1:0]         cfg_mode,
    input  logic               abort,
    output logic               idle,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DWIDTH-1:0]  rsp_data,
    output logic               master_en,
    output logic [INSTR_W-1:0] driver_data,
    output logic [1:0]         driver_cfg,
    input  logic               driver_read,
    input  logic [DWIDTH-1:0]  spi_slv_read_data,
    output logic               master_rst_n
);
    drv_state_e state_r;
    drv_state_e state_s;
    logic       abort_cnt_r;
    logic       rx_pending_r;
    logic [1:0] driver_cfg_r;
    logic       cmd_full_s, cmd_empty_s, rsp_full_s, rsp_empty_s;
    logic [$clog2(CMD_DEPTH):0] cmd_count_unused_s;
    logic [$clog2(RSP_DEPTH):0] rsp_count_unused_s;
    logic       in_abort_s, active_s, stall_s;
    logic       cmd_push_s, cmd_pop_s, rsp_push_s, rsp_pop_s;
    t_type_e    pop_type_s;

    assign in_abort_s   = (state_r == ST_ABORT);
    assign active_s     = (state_r == ST_BUSY) || (state_r == ST_BURST);
    // A read result with nowhere to go holds the master in LOAD
    assign stall_s      = rx_pending_r & driver_read & rsp_full_s;
    assign master_en    = ~rst & (~cmd_empty_s | active_s) & ~stall_s & ~in_abort_s;
    assign cmd_ready    = ~rst & ~cmd_full_s & ~in_abort_s;
    assign cmd_push_s   = cmd_valid & cmd_ready & ~abort;
    assign cmd_pop_s    = driver_read & master_en & ~cmd_empty_s & ~abort;
    assign rsp_push_s   = rx_pending_r & driver_read & ~stall_s & ~abort & ~rst;
    assign rsp_valid    = ~rst & ~rsp_empty_s;
    assign rsp_pop_s    = rsp_valid & rsp_ready;
    assign idle         = ~rst & (state_r == ST_IDLE) & cmd_empty_s & ~rx_pending_r;
    assign master_rst_n = ~rst & ~in_abort_s;
    assign driver_cfg   = driver_cfg_r;
    assign pop_type_s   = get_t_type(driver_data);

    spi_2_fifo #(.WIDTH(INSTR_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .push  (cmd_push_s),
        .pop   (cmd_pop_s),
        .wdata (cmd_data),
        .rdata (driver_data),
        .full  (cmd_full_s),
        .empty (cmd_empty_s),
        .count (cmd_count_unused_s)
    );

    spi_2_fifo #(.WIDTH(DWIDTH), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (rsp_push_s),
        .pop   (rsp_pop_s),
        .wdata (spi_slv_read_data),
        .rdata (rsp_data),
        .full  (rsp_full_s),
        .empty (rsp_empty_s),
        .count (rsp_count_unused_s)
    );

    // Next-state selection; abort overrides every other transition.
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = ST_ABORT;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_pop_s) begin
                        state_s = pop_type_s[1] ? ST_BURST : ST_BUSY;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (driver_read && !stall_s) begin
                        if (cmd_pop_s) begin
                            state_s = pop_type_s[1] ? ST_BURST : ST_BUSY;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        state_s = ST_BUSY;
                    end
                end
                ST_BURST: state_s = ST_BURST;
                ST_ABORT: begin
                    if (abort_cnt_r) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_ABORT;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State, abort timer, outstanding-read flag and mode register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            abort_cnt_r  <= 1'b0;
            rx_pending_r <= 1'b0;
            driver_cfg_r <= 2'b00;
        end else begin
            state_r     <= state_s;
            abort_cnt_r <= in_abort_s & ~abort;
            if (abort) begin
                rx_pending_r <= 1'b0;
            end else if (cmd_pop_s && pop_type_s == T_READ) begin
                rx_pending_r <= 1'b1;
            end else if (rsp_push_s) begin
                rx_pending_r <= 1'b0;
            end
            if (cfg_wr && idle) driver_cfg_r <= cfg_mode;
        end
    end

endmodule

// File: tb/tb_spi_2_driver.sv
// Directed bench for spi_2_driver: a vector table for a write-then-read
// exchange, then hand-written sequences for stall, full FIFO, abort, config and reset.
module tb_spi_2_driver;
    import spi_2_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [INSTR_W-1:0] cmd_data = '0;
    logic               cfg_wr = 1'b0;
    logic [1:0]         cfg_mode = 2'b00;
    logic               abort = 1'b0;
    logic               idle;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [DWIDTH-1:0]  rsp_data;
    logic               master_en;
    logic [INSTR_W-1:0] driver_data;
    logic [1:0]         driver_cfg;
    logic               driver_read = 1'b0;
    logic [DWIDTH-1:0]  spi_slv_read_data = '0;
    logic               master_rst_n;

    int checks = 0;
    int errors = 0;
    int lows;
    int n0;
    logic [INSTR_W-1:0] pop_q [$];

    typedef struct {
        logic               cv;
        logic [INSTR_W-1:0] cd;
        logic               dr;
        logic               rr;
        logic               e_rdy;
        logic               e_men;
        logic               e_idle;
        logic               e_rv;
        logic [DWIDTH-1:0]  e_rd;
    } vec_t;
    vec_t vecs [9];

    spi_2_driver #(.CMD_DEPTH(4), .RSP_DEPTH(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_data          (cmd_data),
        .cfg_wr            (cfg_wr),
        .cfg_mode          (cfg_mode),
        .abort             (abort),
        .idle              (idle),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_data          (rsp_data),
        .master_en         (master_en),
        .driver_data       (driver_data),
        .driver_cfg        (driver_cfg),
        .driver_read       (driver_read),
        .spi_slv_read_data (spi_slv_read_data),
        .master_rst_n      (master_rst_n)
    );

    always #5 clk = ~clk;

    // Record every instruction the master takes (all test instructions are non-zero).
    always @(posedge clk) begin
        if (!rst && driver_read && master_en && driver_data != '0 && !abort)
            pop_q.push_back(driver_data);
    end

    function automatic logic [INSTR_W-1:0] mk(input logic [1:0] t, input logic [7:0] a,
                                              input logic [31:0] d);
        return {t, 3'b000, a, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [INSTR_W-1:0] wr_a, rd_a, rd2, wr2;
        wr_a = mk(2'b00, 8'h10, 32'h1111_1111);
        rd_a = mk(2'b01, 8'h20, 32'h0000_0000);
        rd2  = mk(2'b01, 8'h40, 32'h0000_0000);
        wr2  = mk(2'b00, 8'h41, 32'h2222_2222);

        //            cv    cd     dr    rr    rdy   men   idle  rv    rd
        vecs[0] = '{1'b1, wr_a, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[1] = '{1'b1, rd_a, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{1'b0, '0,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{1'b0, '0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{1'b0, '0,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[5] = '{1'b0, '0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[6] = '{1'b0, '0,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[7] = '{1'b0, '0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5_A5A5};
        vecs[8] = '{1'b0, '0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};

        // Reset values while rst is held
        cyc(); cyc();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_master_en", master_en, 0);
        chk("rst_idle", idle, 0);
        chk("rst_master_rst_n", master_rst_n, 0);
        chk("rst_driver_cfg", driver_cfg, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_master_rst_n", master_rst_n, 1);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_idle", idle, 1);
        cyc();

        // Write then read, table driven
        pop_q.delete();
        spi_slv_read_data = 32'hA5A5_A5A5;
        for (int i = 0; i < 9; i++) begin
            cmd_valid   = vecs[i].cv;
            cmd_data    = vecs[i].cd;
            driver_read = vecs[i].dr;
            rsp_ready   = vecs[i].rr;
            #1;
            chk($sformatf("vec%0d_cmd_ready", i), cmd_ready, vecs[i].e_rdy);
            chk($sformatf("vec%0d_master_en", i), master_en, vecs[i].e_men);
            chk($sformatf("vec%0d_idle", i), idle, vecs[i].e_idle);
            chk($sformatf("vec%0d_rsp_valid", i), rsp_valid, vecs[i].e_rv);
            if (vecs[i].e_rv) chk($sformatf("vec%0d_rsp_data", i), rsp_data, vecs[i].e_rd);
            cyc();
        end
        chk("wr_rd_pop_count", pop_q.size(), 2);
        if (pop_q.size() == 2) begin
            chk("wr_rd_pop0", pop_q[0], wr_a);
            chk("wr_rd_pop1", pop_q[1], rd_a);
        end
        driver_read = 1'b0; rsp_ready = 1'b0; cmd_valid = 1'b0;

        // Stall: fill the response FIFO with four reads, then issue one more
        for (int k = 0; k < 4; k++) begin
            cmd_valid = 1'b1; cmd_data = mk(2'b01, 8'h30 + 8'(k), 32'h0); driver_read = 1'b0;
            cyc();
            cmd_valid = 1'b0; driver_read = 1'b1;
            cyc();
            spi_slv_read_data = 32'hD000_0000 + 32'(k);
            cyc();
            driver_read = 1'b0;
            cyc();
        end
        chk("stall_prefill_rsp_valid", rsp_valid, 1);
        pop_q.delete();
        cmd_valid = 1'b1; cmd_data = rd2; cyc();
        cmd_data = wr2; cyc();
        cmd_valid = 1'b0; driver_read = 1'b1; spi_slv_read_data = 32'hBEEF_0001;
        cyc();
        chk("stall_master_en_0", master_en, 0);
        chk("stall_idle", idle, 0);
        cyc();
        chk("stall_master_en_1", master_en, 0);
        chk("stall_no_pop", pop_q.size(), 1);
        rsp_ready = 1'b1;
        #1;
        chk("stall_drain_cycle_master_en", master_en, 0);
        cyc();
        rsp_ready = 1'b0;
        #1;
        chk("stall_release_master_en", master_en, 1);
        n0 = pop_q.size();
        cyc();
        chk("stall_next_pop_count", pop_q.size(), n0 + 1);
        if (pop_q.size() == n0 + 1) chk("stall_next_pop_data", pop_q[n0], wr2);
        cyc();
        driver_read = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            #1;
            chk($sformatf("stall_rsp_valid%0d", k), rsp_valid, 1);
            chk($sformatf("stall_rsp_data%0d", k), rsp_data,
                (k < 4) ? (32'hD000_0000 + 32'(k)) : 32'hBEEF_0001);
            cyc();
        end
        rsp_ready = 1'b0;
        #1;
        chk("stall_rsp_drained", rsp_valid, 0);
        chk("stall_end_idle", idle, 1);
        cyc();

        // Command FIFO full: five back-to-back pushes with the master held
        pop_q.delete();
        driver_read = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_data = mk(2'b00, 8'h50 + 8'(i), 32'hC0 + 32'(i));
            #1;
            chk($sformatf("full_cmd_ready%0d", i), cmd_ready, (i < 4) ? 1 : 0);
            cyc();
        end
        cmd_valid = 1'b0; driver_read = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        driver_read = 1'b0;
        chk("full_pop_count", pop_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < pop_q.size())
                chk($sformatf("full_pop_order%0d", i), pop_q[i], mk(2'b00, 8'h50 + 8'(i), 32'hC0 + 32'(i)));
        end
        #1;
        chk("full_end_idle", idle, 1);
        cyc();

        // Burst then abort
        pop_q.delete();
        cmd_valid = 1'b1; cmd_data = mk(2'b10, 8'h60, 32'h1234_5678); cyc();
        cmd_valid = 1'b0; driver_read = 1'b1; cyc();
        for (int i = 0; i < 19; i++) begin
            driver_read = i[0];
            cyc();
        end
        driver_read = 1'b0; cmd_valid = 1'b1; cmd_data = mk(2'b00, 8'h61, 32'h1); cyc();
        chk("burst_idle", idle, 0);
        chk("burst_master_en", master_en, 1);
        abort = 1'b1; driver_read = 1'b1; cmd_data = mk(2'b00, 8'h62, 32'h2);
        cyc();
        abort = 1'b0; cmd_valid = 1'b0; driver_read = 1'b0;
        lows = 0;
        for (int j = 0; j < 5; j++) begin
            if (!master_rst_n) lows++;
            if (j == 0) begin
                chk("abort_master_rst_n_first", master_rst_n, 0);
                chk("abort_cmd_ready", cmd_ready, 0);
                chk("abort_master_en", master_en, 0);
            end
            cyc();
        end
        chk("abort_rst_low_cycles", lows, 2);
        chk("abort_end_idle", idle, 1);
        chk("abort_end_master_en", master_en, 0);
        chk("abort_end_master_rst_n", master_rst_n, 1);
        chk("abort_pop_count", pop_q.size(), 1);

        // Config while busy is ignored, while idle takes one cycle
        cmd_valid = 1'b1; cmd_data = mk(2'b00, 8'h70, 32'h1); cyc();
        cmd_valid = 1'b0; driver_read = 1'b1; cyc();
        driver_read = 1'b0; cfg_wr = 1'b1; cfg_mode = 2'b11;
        #1;
        chk("cfg_busy_idle", idle, 0);
        cyc();
        cfg_wr = 1'b0;
        chk("cfg_busy_ignored", driver_cfg, 2'b00);
        driver_read = 1'b1; cyc();
        driver_read = 1'b0; cfg_wr = 1'b1; cfg_mode = 2'b11;
        #1;
        chk("cfg_idle_idle", idle, 1);
        chk("cfg_idle_before_edge", driver_cfg, 2'b00);
        cyc();
        cfg_wr = 1'b0;
        chk("cfg_idle_applied", driver_cfg, 2'b11);

        // Reset in the middle of a read
        cmd_valid = 1'b1; cmd_data = mk(2'b01, 8'h80, 32'h0); cyc();
        cmd_valid = 1'b0; driver_read = 1'b1; cyc();
        driver_read = 1'b0; spi_slv_read_data = 32'hCAFE_F00D; cyc();
        driver_read = 1'b1; rst = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_master_en", master_en, 0);
        chk("mid_rst_idle", idle, 0);
        chk("mid_rst_master_rst_n", master_rst_n, 0);
        cyc();
        chk("mid_rst_driver_cfg", driver_cfg, 2'b00);
        chk("mid_rst_rsp_valid2", rsp_valid, 0);
        rst = 1'b0; driver_read = 1'b0;
        #1;
        chk("mid_rst_after_cmd_ready", cmd_ready, 1);
        chk("mid_rst_after_idle", idle, 1);
        chk("mid_rst_after_master_rst_n", master_rst_n, 1);
        cyc();
        chk("mid_rst_no_response", rsp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
